// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_WB = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam int STG_PC = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status in, stage control and statistics out
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
);
  logic enable;
  logic [REG_ADDR_W-1:0] rs_id, rt_id, waddr_ex, waddr_mem;
  logic rs_used_id, rt_used_id, reg_write_ex, mem_read_ex, reg_write_mem;
  logic redirect_mem, dmem_req, dmem_ready;
  logic [4:0] stage_en, flush;
  logic bubble_ex, mem_timeout;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output enable, rs_id, rt_id, rs_used_id, rt_used_id, waddr_ex, reg_write_ex, mem_read_ex,
           waddr_mem, reg_write_mem, redirect_mem, dmem_req, dmem_ready,
    input stage_en, bubble_ex, flush, fwd_rs_sel, fwd_rt_sel, mem_timeout, stall_cnt, flush_cnt
  );
  modport slave (
    input enable, rs_id, rt_id, rs_used_id, rt_used_id, waddr_ex, reg_write_ex, mem_read_ex,
          waddr_mem, reg_write_mem, redirect_mem, dmem_req, dmem_ready,
    output stage_en, bubble_ex, flush, fwd_rs_sel, fwd_rt_sel, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// fwd_select: EX operand forwarding source for one ID operand
module fwd_select import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = 5
) (
  input logic [REG_ADDR_W-1:0] addr,
  input logic used,
  input logic [REG_ADDR_W-1:0] waddr_ex,
  input logic reg_write_ex,
  input logic mem_read_ex,
  input logic [REG_ADDR_W-1:0] waddr_mem,
  input logic reg_write_mem,
  output logic [1:0] sel
);
  always_comb
    sel = !used ? FWD_REGFILE
        : (reg_write_ex && !mem_read_ex && waddr_ex != '0 && addr == waddr_ex) ? FWD_MEM
        : (reg_write_mem && waddr_mem != '0 && addr == waddr_mem) ? FWD_WB
        : FWD_REGFILE;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage enables, bubbles, flushes, forwarding selects and stall/flush
// statistics for the 5-stage core, including data-memory wait states with timeout
module pipeline_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  state_t state, state_nxt;
  logic [7:0] wcnt;
  logic [1:0] rs_sel, rt_sel;
  logic active, timeout, mem_wait, hazard, redirect, load_use;
  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .addr(bus.rs_id), .used(bus.rs_used_id), .waddr_ex(bus.waddr_ex),
    .reg_write_ex(bus.reg_write_ex), .mem_read_ex(bus.mem_read_ex),
    .waddr_mem(bus.waddr_mem), .reg_write_mem(bus.reg_write_mem), .sel(rs_sel)
  );
  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .addr(bus.rt_id), .used(bus.rt_used_id), .waddr_ex(bus.waddr_ex),
    .reg_write_ex(bus.reg_write_ex), .mem_read_ex(bus.mem_read_ex),
    .waddr_mem(bus.waddr_mem), .reg_write_mem(bus.reg_write_mem), .sel(rt_sel)
  );
  // The cycle that ends a wait (ready or timeout) falls through to the normal rules.
  always_comb begin
    active = state != IDLE;
    timeout = state == MEM_WAIT && !bus.dmem_ready && wcnt == 8'(WAIT_MAX);
    mem_wait = (state == MEM_WAIT && !bus.dmem_ready && !timeout) ||
               (state == RUN && bus.dmem_req && !bus.dmem_ready);
    hazard = bus.mem_read_ex && bus.reg_write_ex && bus.waddr_ex != '0 &&
             ((bus.rs_used_id && bus.waddr_ex == bus.rs_id) ||
              (bus.rt_used_id && bus.waddr_ex == bus.rt_id));
    redirect = active && !mem_wait && bus.redirect_mem;
    load_use = active && !mem_wait && !bus.redirect_mem && hazard;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = !bus.enable ? IDLE
              : state == IDLE ? RUN
              : mem_wait ? MEM_WAIT
              : RUN;
  always_comb begin
    bus.stage_en = (rst || !active || mem_wait) ? 5'b00000 : load_use ? 5'b11000 : 5'b11111;
    bus.flush = (!rst && redirect) ? 5'b01110 : 5'b00000;
    bus.bubble_ex = !rst && load_use;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      bus.mem_timeout <= 1'b0;
      bus.fwd_rs_sel <= FWD_REGFILE;
      bus.fwd_rt_sel <= FWD_REGFILE;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      wcnt <= state_nxt == MEM_WAIT ? wcnt + 8'd1 : 8'd0;
      bus.mem_timeout <= bus.mem_timeout | timeout;
      if (bus.bubble_ex || bus.flush[STG_ID_EX]) begin
        bus.fwd_rs_sel <= FWD_REGFILE;
        bus.fwd_rt_sel <= FWD_REGFILE;
      end else if (bus.stage_en[STG_ID_EX]) begin
        bus.fwd_rs_sel <= rs_sel;
        bus.fwd_rt_sel <= rt_sel;
      end
      if ((mem_wait || load_use) && bus.stall_cnt != '1)
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      if (redirect && bus.flush_cnt != '1)
        bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors, corner-case sequences and a randomized run
// against a cycle-level reference model of the controller rules
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5, WM = 4, CW = 4, CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  int nvec = 0, nfail = 0;
  bit m_on, m_to;
  int m_wait, m_stall, m_flush;
  logic [1:0] m_rs, m_rt;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus();
  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {
    logic en;
    logic [AW-1:0] rs;
    logic rsu;
    logic [AW-1:0] rt;
    logic rtu;
    logic [AW-1:0] wex;
    logic rwex, mrex;
    logic [AW-1:0] wmem;
    logic rwmem, redir, req, rdy;
    logic [4:0] se;
    logic bub;
    logic [4:0] fl;
    logic [1:0] frs, frt;
  } vec_t;
  function automatic vec_t mk(int en, int rs, int rsu, int rt, int rtu, int wex, int rwex, int mrex,
                              int wmem, int rwmem, int redir, int req, int rdy,
                              int se, int bub, int fl, int frs, int frt);
    vec_t v;
    v.en = 1'(en); v.rs = AW'(rs); v.rsu = 1'(rsu); v.rt = AW'(rt); v.rtu = 1'(rtu);
    v.wex = AW'(wex); v.rwex = 1'(rwex); v.mrex = 1'(mrex); v.wmem = AW'(wmem);
    v.rwmem = 1'(rwmem); v.redir = 1'(redir); v.req = 1'(req); v.rdy = 1'(rdy);
    v.se = 5'(se); v.bub = 1'(bub); v.fl = 5'(fl); v.frs = 2'(frs); v.frt = 2'(frt);
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #4; endtask
  task automatic zero_in();
    bus.enable = 0; bus.rs_id = '0; bus.rt_id = '0; bus.rs_used_id = 0; bus.rt_used_id = 0;
    bus.waddr_ex = '0; bus.reg_write_ex = 0; bus.mem_read_ex = 0; bus.waddr_mem = '0;
    bus.reg_write_mem = 0; bus.redirect_mem = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask
  task automatic apply(vec_t v);
    bus.enable = v.en; bus.rs_id = v.rs; bus.rs_used_id = v.rsu; bus.rt_id = v.rt;
    bus.rt_used_id = v.rtu; bus.waddr_ex = v.wex; bus.reg_write_ex = v.rwex;
    bus.mem_read_ex = v.mrex; bus.waddr_mem = v.wmem; bus.reg_write_mem = v.rwmem;
    bus.redirect_mem = v.redir; bus.dmem_req = v.req; bus.dmem_ready = v.rdy;
  endtask
  task automatic chk_out(string n, logic [4:0] se, logic bub, logic [4:0] fl,
                         logic [1:0] frs, logic [1:0] frt);
    chk({n, "_stage_en"}, 32'(bus.stage_en), 32'(se));
    chk({n, "_bubble"}, 32'(bus.bubble_ex), 32'(bub));
    chk({n, "_flush"}, 32'(bus.flush), 32'(fl));
    chk({n, "_fwd_rs"}, 32'(bus.fwd_rs_sel), 32'(frs));
    chk({n, "_fwd_rt"}, 32'(bus.fwd_rt_sel), 32'(frt));
  endtask
  task automatic chk_cnt(string n, int st, int fc, int to);
    chk({n, "_stall_cnt"}, 32'(bus.stall_cnt), st);
    chk({n, "_flush_cnt"}, 32'(bus.flush_cnt), fc);
    chk({n, "_timeout"}, 32'(bus.mem_timeout), to);
  endtask
  function automatic logic [1:0] fwd_ref(logic [AW-1:0] a, logic used);
    if (!used) return 2'd0;
    if (bus.reg_write_ex && !bus.mem_read_ex && bus.waddr_ex != 0 && a == bus.waddr_ex) return 2'd2;
    if (bus.reg_write_mem && bus.waddr_mem != 0 && a == bus.waddr_mem) return 2'd1;
    return 2'd0;
  endfunction
  // One cycle of the reference: expected outputs from current inputs, then the state after the edge.
  task automatic model_step();
    logic [4:0] se = '0, fl = '0;
    logic bub = 0;
    bit stall = 0, give_up = 0, lu = 0;
    bit use_hit = (bus.rs_used_id && bus.rs_id == bus.waddr_ex) ||
                  (bus.rt_used_id && bus.rt_id == bus.waddr_ex);
    if (!rst && m_on) begin
      if (m_wait > 0) begin
        give_up = !bus.dmem_ready && m_wait == WM;
        stall = !bus.dmem_ready && !give_up;
      end else stall = bus.dmem_req && !bus.dmem_ready;
      if (!stall) begin
        lu = !bus.redirect_mem && bus.mem_read_ex && bus.reg_write_ex && bus.waddr_ex != 0 && use_hit;
        se = lu ? 5'b11000 : 5'b11111;
        fl = bus.redirect_mem ? 5'b01110 : 5'b00000;
        bub = lu;
      end
    end
    chk_out("rnd", se, bub, fl, m_rs, m_rt);
    chk_cnt("rnd", m_stall, m_flush, int'(m_to));
    if (rst) begin
      m_on = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_rs = 0; m_rt = 0;
    end else begin
      if (bub || fl[2]) begin
        m_rs = 0; m_rt = 0;
      end else if (se[2]) begin
        m_rs = fwd_ref(bus.rs_id, bus.rs_used_id);
        m_rt = fwd_ref(bus.rt_id, bus.rt_used_id);
      end
      if ((stall || lu) && m_stall < CMAX) m_stall++;
      if (fl != 0 && m_flush < CMAX) m_flush++;
      if (give_up) m_to = 1;
      m_wait = (m_on && stall && bus.enable) ? m_wait + 1 : 0;
      m_on = bus.enable;
    end
  endtask
  initial begin
    vec_t tbl[15];
    // en rs rsu rt rtu wex rwex mrex wmem rwmem redir req rdy | se bub fl frs frt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 3, 1, 7, 1, 3, 1, 0, 0, 0, 0, 0, 0, 'b11111, 0, 0, 0, 0);
    tbl[3]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 'b11111, 0, 0, 2, 0);
    tbl[4]  = mk(1, 0, 0, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 'b11000, 1, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 5, 1, 0, 0, 0, 'b11111, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 'b11111, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'b11111, 0, 0, 0, 0);
    tbl[8]  = mk(1, 9, 1, 4, 1, 9, 1, 1, 4, 1, 1, 0, 0, 'b11111, 0, 'b01110, 0, 0);
    tbl[9]  = mk(1, 4, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 'b11111, 0, 0, 0, 0);
    tbl[10] = mk(1, 4, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b11111, 0, 0, 1, 0);
    tbl[12] = mk(1, 6, 1, 6, 1, 6, 1, 0, 0, 0, 0, 0, 0, 'b11111, 0, 0, 0, 0);
    tbl[13] = mk(1, 7, 1, 7, 0, 7, 1, 0, 7, 1, 0, 0, 0, 'b11111, 0, 0, 2, 2);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b11111, 0, 0, 2, 0);
    zero_in(); rst = 1; tick(); tick();
    settle(); chk_out("reset", 0, 0, 0, 0, 0); chk_cnt("reset", 0, 0, 0); tick();
    rst = 0;
    foreach (tbl[i]) begin
      apply(tbl[i]); settle();
      chk_out($sformatf("vec%0d", i), tbl[i].se, tbl[i].bub, tbl[i].fl, tbl[i].frs, tbl[i].frt);
      tick();
    end
    zero_in(); bus.enable = 1; settle(); chk_cnt("after_table", 2, 1, 0); tick();
    // wait states: three cycles then ready, then a timeout with ready never arriving
    zero_in(); rst = 1; settle(); chk("rst_stage_en", 32'(bus.stage_en), 0); tick();
    rst = 0; bus.enable = 1; settle(); chk("idle_stage_en", 32'(bus.stage_en), 0); tick();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int k = 0; k < 3; k++) begin settle(); chk("wait_stage_en", 32'(bus.stage_en), 0); tick(); end
    bus.dmem_ready = 1; settle();
    chk("resume_stage_en", 32'(bus.stage_en), 'b11111); chk_cnt("resume", 3, 0, 0); tick();
    bus.dmem_ready = 0;
    for (int k = 0; k < 4; k++) begin settle(); chk("to_wait_stage_en", 32'(bus.stage_en), 0); tick(); end
    settle(); chk("to_release_stage_en", 32'(bus.stage_en), 'b11111); chk_cnt("to_release", 7, 0, 0); tick();
    bus.dmem_req = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("to_run_stage_en", 32'(bus.stage_en), 'b11111); chk_cnt("to_sticky", 7, 0, 1); tick();
    end
    // reset in the middle of a memory wait
    bus.reg_write_ex = 1; bus.waddr_ex = 3; bus.rs_id = 3; bus.rs_used_id = 1; settle(); tick();
    zero_in(); bus.enable = 1; bus.dmem_req = 1; settle(); chk("pre_rst_fwd_rs", 32'(bus.fwd_rs_sel), 2); tick();
    settle(); chk("mid_wait_stage_en", 32'(bus.stage_en), 0); tick();
    rst = 1; settle(); chk("rst_mid_stage_en", 32'(bus.stage_en), 0); tick();
    rst = 0; zero_in(); settle(); chk_out("post_rst", 0, 0, 0, 0, 0); chk_cnt("post_rst", 0, 0, 0); tick();
    settle(); chk("post_rst_idle", 32'(bus.stage_en), 0); tick();
    bus.enable = 1; settle(); chk("post_rst_en_idle", 32'(bus.stage_en), 0); tick();
    settle(); chk("post_rst_run", 32'(bus.stage_en), 'b11111); tick();
    // randomized run against the reference model
    zero_in(); rst = 1; tick(); rst = 0;
    m_on = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_rs = 0; m_rt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      bus.enable = ($urandom_range(19) != 0);
      bus.rs_id = AW'($urandom_range(3)); bus.rt_id = AW'($urandom_range(3));
      bus.rs_used_id = 1'($urandom_range(1)); bus.rt_used_id = 1'($urandom_range(1));
      bus.waddr_ex = AW'($urandom_range(3)); bus.reg_write_ex = 1'($urandom_range(1));
      bus.mem_read_ex = 1'($urandom_range(1)); bus.waddr_mem = AW'($urandom_range(3));
      bus.reg_write_mem = 1'($urandom_range(1)); bus.redirect_mem = ($urandom_range(7) == 0);
      bus.dmem_req = ($urandom_range(2) == 0); bus.dmem_ready = 1'($urandom_range(1));
      settle(); model_step(); tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Centralised pipeline controller for the 5-stage MIPS core; replaces the ad-hoc enable, stall and forwarding logic.
- Produces per-stage register enables, a bubble request for ID/EX, and per-stage flushes on a redirect resolved in MEM.
- Produces registered forwarding selects for the EX operand muxes.
- Adds two behaviours the current core lacks: data-memory wait-state handling with a timeout, and saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- WAIT_MAX, 15, maximum consecutive data-memory wait cycles before timeout; 1..255.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global run enable.
- rs_id  in  REG_ADDR_W  rs field of the instruction in ID.
- rt_id  in  REG_ADDR_W  rt field of the instruction in ID.
- rs_used_id  in  1  instruction in ID reads rs.
- rt_used_id  in  1  instruction in ID reads rt.
- waddr_ex  in  REG_ADDR_W  destination register of the instruction in EX.
- reg_write_ex  in  1  instruction in EX writes a register.
- mem_read_ex  in  1  instruction in EX is a load.
- waddr_mem  in  REG_ADDR_W  destination register of the instruction in MEM.
- reg_write_mem  in  1  instruction in MEM writes a register.
- redirect_mem  in  1  taken branch or jump resolved in MEM.
- dmem_req  in  1  MEM-stage data-memory access this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- stage_en  out  5  enables: [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB.
- bubble_ex  out  1  ID/EX loads a NOP (all control bits 0).
- flush  out  5  per-boundary clear, bit indices as stage_en.
- fwd_rs_sel  out  2  EX rs mux select: 0 = regfile, 1 = WB data, 2 = MEM ALU out.
- fwd_rt_sel  out  2  EX rt mux select, same encoding.
- mem_timeout  out  1  sticky timeout error.
- stall_cnt  out  CNT_W  count of cycles lost to stalls.
- flush_cnt  out  CNT_W  count of redirects.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FSM goes to IDLE.
  - fwd_rs_sel and fwd_rt_sel = 0; mem_timeout = 0; counters = 0; wait counter = 0.
  - While rst=1, stage_en=0, flush=0 and bubble_ex=0, forced combinationally.
- FSM states:
  - IDLE: stage_en=0.
  - RUN: normal operation.
  - MEM_WAIT: data-memory access in progress.
- FSM transitions:
  - IDLE→RUN when enable=1.
  - Any state→IDLE when enable=0 (next edge). On this transition, held selects and counters are preserved.
  - RUN→MEM_WAIT when dmem_req=1 and dmem_ready=0.
  - MEM_WAIT→RUN when dmem_ready=1, or when the wait counter reaches WAIT_MAX. The timeout case sets mem_timeout=1, which stays set until reset.
- Rules in RUN and MEM_WAIT, evaluated in the priority order below:
  1. Memory wait (state MEM_WAIT, or in RUN dmem_req=1 and dmem_ready=0):
     - stage_en=0; whole pipe frozen; the redirect and load-use rules are ignored this cycle.
     - stall_cnt increments; the wait counter increments.
     - The cycle that completes the access (ready or timeout) behaves as RUN.
  2. Redirect (redirect_mem=1):
     - stage_en=5'b11111; flush=5'b01110, so IF/ID, ID/EX and EX/MEM are cleared.
     - flush_cnt increments.
     - Any load-use stall in that cycle is dropped.
  3. Load-use hazard. Condition:
     - mem_read_ex=1, reg_write_ex=1 and waddr_ex≠0;
     - and waddr_ex==rs_id with rs_used_id=1, or waddr_ex==rt_id with rt_used_id=1.
     Response:
     - stage_en=5'b11000; bubble_ex=1; stall_cnt increments.
     - The stall lasts exactly 1 cycle, because the load then sits in MEM and the WB path covers it.
  4. Otherwise: stage_en=5'b11111; flush=0; bubble_ex=0.
- Forwarding selects are computed in ID and registered at the edge where stage_en[2]=1, so they are valid for the instruction that enters EX.
  - Per operand:
    - Select 2 if reg_write_ex=1, mem_read_ex=0, waddr_ex≠0 and the operand address matches waddr_ex.
    - Else select 1 if reg_write_mem=1, waddr_mem≠0 and the operand matches waddr_mem.
    - Else select 0.
  - An unused operand (rs_used_id / rt_used_id = 0) gets select 0.
  - Bubble or flush of ID/EX forces the registered select to 0.
  - When stage_en[2]=0 and there is no bubble/flush, the registered select holds.
- The register file performs write-before-read. Conflicts between the instruction in ID and the instruction in WB are therefore not handled here.
- Counters saturate at all-ones; they do not wrap.
- The wait counter clears on every exit from MEM_WAIT.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - Forwarding select constants FWD_REGFILE=0, FWD_WB=1, FWD_MEM=2.
  - Stage index constants STG_PC..STG_MEM_WB.
  - FSM state encoding IDLE/RUN/MEM_WAIT.
- One sub-module: fwd_select.
  - Combinational per-operand select logic.
  - Instantiated twice, once for rs and once for rt.

Test Plan:
1. Back-to-back ALU ops:
   - Stimulus: `add $3` in EX (reg_write_ex=1, waddr_ex=3); rs_id=3 in ID.
   - Required: fwd_rs_sel=2 after the edge.
   - Next cycle (producer in MEM, waddr_mem=3, consumer now in ID): fwd_rs_sel=1.
2. Load-use:
   - Stimulus: mem_read_ex=1, waddr_ex=5, rt_id=5, rt_used_id=1.
   - Required: one cycle of stage_en=11000 and bubble_ex=1; stall_cnt=1.
   - Then stage_en=11111 and fwd_rt_sel=1.
3. Register $0:
   - Stimulus: reg_write_ex=1, waddr_ex=0, rs_id=0.
   - Required: fwd_rs_sel=0; no stall even when mem_read_ex=1.
4. Redirect with a simultaneous load-use hazard:
   - Stimulus: redirect_mem=1 in the same cycle as a load-use hazard.
   - Required: flush=01110; stage_en=11111; bubble_ex=0; flush_cnt increments by 1; stall_cnt unchanged.
5. Wait states:
   - Stimulus: dmem_req=1 with dmem_ready low for 3 cycles.
   - Required: stage_en=0 for 3 cycles; stall_cnt=3; resume on ready.
   - Timeout variant: ready never arrives with WAIT_MAX=4. Required: release after 4 cycles and mem_timeout=1 until rst.
6. Reset mid-stall:
   - Stimulus: assert rst during MEM_WAIT.
   - Required: next edge gives IDLE, counters 0, mem_timeout 0, selects 0.
   - Required: after release, stage_en=0 until enable=1.
